// File: rtl/modexp_seq.sv
// modexp_seq: square-and-multiply sequencer driving one montprod core, ping-ponging results between R0 and R1.
// Define MODEXP_SEQ_FINAL_CONV_EN to append a multiply by plain 1 that leaves the result in the normal domain.
module modexp_seq #(
    parameter int EXP_ADDR_W   = 8,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [7:0]            length,
    input  logic [7:0]            exp_length,
    output logic [EXP_ADDR_W-1:0] exp_addr,
    input  logic [31:0]           exp_data,
    output logic                  mp_calculate,
    input  logic                  mp_ready,
    output logic [7:0]            mp_length,
    output logic [2:0]            mp_opa_sel,
    output logic [2:0]            mp_opb_sel,
    output logic                  mp_dst_sel,
    output logic [2:0]            result_sel
);

    localparam logic [2:0] SEL_P    = 3'd2;
    localparam logic [2:0] SEL_ONE  = 3'd3;
    localparam logic [2:0] SEL_LIT1 = 3'd4;
    localparam logic [1:0] GUARD_INIT = 2'(GUARD_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        NEXT,
`ifdef MODEXP_SEQ_FINAL_CONV_EN
        CONV_START,
        CONV_WAIT,
`endif
        DONE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  exp_len_q;
    logic [31:0] word_q;
    logic [7:0]  w_q;
    logic [4:0]  b_q;
    logic [2:0]  cur_q;
    logic [1:0]  guard_q;

    logic in_wait;
    logic wait_done;
    logic bit_set;
    logic last_word;

    assign exp_addr  = EXP_ADDR_W'(w_q);
    assign bit_set   = word_q[b_q];
    assign last_word = (w_q == exp_len_q - 8'd1);

`ifdef MODEXP_SEQ_FINAL_CONV_EN
    assign in_wait      = (state == SQ_WAIT) || (state == MUL_WAIT) || (state == CONV_WAIT);
    assign mp_calculate = (state == SQ_START) || (state == MUL_START) || (state == CONV_START);
`else
    assign in_wait      = (state == SQ_WAIT) || (state == MUL_WAIT);
    assign mp_calculate = (state == SQ_START) || (state == MUL_START);
`endif

    // montprod drops ready a cycle late, so its ready is masked for a few cycles after each pulse
    assign wait_done = in_wait && (guard_q == 2'd0) && mp_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (exp_length != 8'd0) state_n = FETCH;
`ifdef MODEXP_SEQ_FINAL_CONV_EN
                    else                    state_n = CONV_START;
`else
                    else                    state_n = DONE;
`endif
                end
            end
            FETCH:     state_n = LATCH;
            LATCH:     state_n = SQ_START;
            SQ_START:  state_n = SQ_WAIT;
            SQ_WAIT:   if (wait_done) state_n = bit_set ? MUL_START : NEXT;
            MUL_START: state_n = MUL_WAIT;
            MUL_WAIT:  if (wait_done) state_n = NEXT;
            NEXT: begin
                if (b_q != 5'd0)    state_n = SQ_START;
`ifdef MODEXP_SEQ_FINAL_CONV_EN
                else if (last_word) state_n = CONV_START;
`else
                else if (last_word) state_n = DONE;
`endif
                else                state_n = FETCH;
            end
`ifdef MODEXP_SEQ_FINAL_CONV_EN
            CONV_START: state_n = CONV_WAIT;
            CONV_WAIT:  if (wait_done) state_n = DONE;
`endif
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Selects are loaded on the edge entering each *_START and held until the matching wait ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready      <= 1'b1;
            mp_length  <= '0;
            exp_len_q  <= '0;
            word_q     <= '0;
            w_q        <= '0;
            b_q        <= '0;
            cur_q      <= SEL_ONE;
            guard_q    <= '0;
            mp_opa_sel <= SEL_ONE;
            mp_opb_sel <= SEL_ONE;
            mp_dst_sel <= 1'b0;
            result_sel <= SEL_ONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready     <= 1'b0;
                        mp_length <= length;
                        exp_len_q <= exp_length;
                        cur_q     <= SEL_ONE;
                        w_q       <= '0;
                        b_q       <= 5'd31;
`ifdef MODEXP_SEQ_FINAL_CONV_EN
                        if (exp_length == 8'd0) begin
                            mp_opa_sel <= SEL_ONE;
                            mp_opb_sel <= SEL_LIT1;
                            mp_dst_sel <= 1'b0;
                        end
`endif
                    end
                end
                LATCH: begin
                    word_q     <= exp_data;
                    mp_opa_sel <= cur_q;
                    mp_opb_sel <= cur_q;
                    mp_dst_sel <= ~cur_q[0];
                end
                NEXT: begin
                    if (b_q != 5'd0) begin
                        b_q        <= b_q - 5'd1;
                        mp_opa_sel <= cur_q;
                        mp_opb_sel <= cur_q;
                        mp_dst_sel <= ~cur_q[0];
                    end else if (last_word) begin
`ifdef MODEXP_SEQ_FINAL_CONV_EN
                        mp_opa_sel <= cur_q;
                        mp_opb_sel <= SEL_LIT1;
                        mp_dst_sel <= ~cur_q[0];
`endif
                    end else begin
                        w_q <= w_q + 8'd1;
                        b_q <= 5'd31;
                    end
                end
                DONE: begin
                    result_sel <= cur_q;
                    ready      <= 1'b1;
                end
                default: ;
            endcase

            if (mp_calculate) guard_q <= GUARD_INIT;

            if (in_wait && guard_q != 2'd0) guard_q <= guard_q - 2'd1;

            if (wait_done) begin
                cur_q <= {2'b00, mp_dst_sel};
                // square result feeds the multiply directly; cur_q is not yet visible
                if (state == SQ_WAIT && bit_set) begin
                    mp_opa_sel <= {2'b00, mp_dst_sel};
                    mp_opb_sel <= SEL_P;
                    mp_dst_sel <= ~mp_dst_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq: random exponents against an op-list reference model, with a montprod stand-in.
module tb_modexp_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [7:0]  length;
    logic [7:0]  exp_length;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic        mp_calculate;
    logic        mp_ready;
    logic [7:0]  mp_length;
    logic [2:0]  mp_opa_sel;
    logic [2:0]  mp_opb_sel;
    logic        mp_dst_sel;
    logic [2:0]  result_sel;

    always #5 clk = ~clk;

    modexp_seq #(.EXP_ADDR_W(8), .GUARD_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .length(length), .exp_length(exp_length),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .mp_calculate(mp_calculate), .mp_ready(mp_ready), .mp_length(mp_length),
        .mp_opa_sel(mp_opa_sel), .mp_opb_sel(mp_opb_sel), .mp_dst_sel(mp_dst_sel),
        .result_sel(result_sel)
    );

    logic [31:0] mem [256];
    always @(posedge clk) exp_data <= mem[exp_addr];

    // montprod stand-in: busy for 10 cycles per pulse, logs every (opa, opb, dst)
    logic [6:0] log_q[$];
    int busy = 0;
    int viol = 0;
    int instab = 0;
    always @(posedge clk) begin
        if (reset) begin
            mp_ready <= 1'b1;
            busy     <= 0;
        end else if (mp_calculate) begin
            if (!mp_ready) viol <= viol + 1;
            log_q.push_back({mp_opa_sel, mp_opb_sel, mp_dst_sel});
            mp_ready <= 1'b0;
            busy     <= 10;
        end else begin
            if (busy != 0) begin
                busy <= busy - 1;
                if (busy == 1) mp_ready <= 1'b1;
            end
            if (!mp_ready && log_q.size() != 0 &&
                {mp_opa_sel, mp_opb_sel, mp_dst_sel} != log_q[$]) instab <= instab + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [7:0] addr_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // the bank a result goes to is whichever of R0/R1 is not holding the current value
    function automatic logic other_bank(input logic [2:0] c);
        return (c == 3'd0);
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, ready, 1);
        chk({pfx, "_calc"}, mp_calculate, 0);
        chk({pfx, "_sels"}, {mp_opa_sel, mp_opb_sel, mp_dst_sel}, {3'd3, 3'd3, 1'b0});
        chk({pfx, "_result_sel"}, result_sel, 3);
        chk({pfx, "_exp_addr"}, exp_addr, 0);
        chk({pfx, "_mp_length"}, mp_length, 0);
    endtask

    task automatic run_case(input string tag, input int elen, input logic [7:0] len,
                            input bit hammer, output int cyc);
        logic [6:0] expq[$];
        logic [2:0] cur;
        int base, v0, i0, bad, lenbad, got;
        base = log_q.size();
        v0 = viol;
        i0 = instab;
        cur = 3'd3;
        for (int w = 0; w < elen; w++)
            for (int b = 31; b >= 0; b--) begin
                expq.push_back({cur, cur, other_bank(cur)});
                cur = {2'b00, other_bank(cur)};
                if (mem[w][b]) begin
                    expq.push_back({cur, 3'd2, other_bank(cur)});
                    cur = {2'b00, other_bank(cur)};
                end
            end
`ifdef MODEXP_SEQ_FINAL_CONV_EN
        expq.push_back({cur, 3'd4, other_bank(cur)});
        cur = {2'b00, other_bank(cur)};
`endif
        @(negedge clk);
        length = len;
        exp_length = elen[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({tag, "_ready_drop"}, ready, 0);
        chk({tag, "_mp_length"}, mp_length, len);
        addr_q.delete();
        addr_q.push_back(exp_addr);
        lenbad = 0;
        while (!ready && cyc < 30000) begin
            if (hammer) begin
                start = (cyc % 3 == 0);
                length = 8'h55;
            end
            @(negedge clk);
            cyc++;
            if (mp_length != len) lenbad++;
            if (exp_addr != addr_q[$]) addr_q.push_back(exp_addr);
        end
        start = 1'b0;
        length = len;
        chk({tag, "_done"}, ready, 1);
        got = log_q.size() - base;
        chk({tag, "_op_count"}, got, expq.size());
        bad = 0;
        for (int i = 0; i < got && i < expq.size(); i++)
            if (log_q[base + i] != expq[i]) bad++;
        chk({tag, "_op_seq"}, bad, 0);
        chk({tag, "_result_sel"}, result_sel, cur);
        chk({tag, "_calc_while_busy"}, viol - v0, 0);
        chk({tag, "_sel_hold"}, instab - i0, 0);
        if (hammer) chk({tag, "_len_held"}, lenbad, 0);
    endtask

    initial begin
        int cyc, n, base, elen;
        reset = 1'b1;
        start = 1'b0;
        length = 8'h00;
        exp_length = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");

        mem[0] = 32'h8000_0000;
        base = log_q.size();
        run_case("msb", 1, 8'h20, 0, cyc);
        chk("msb_first_op", log_q[base], {3'd3, 3'd3, 1'b0});
        chk("msb_second_op", log_q[base + 1], {3'd0, 3'd2, 1'b1});
        chk("msb_count_33", log_q.size() - base,
`ifdef MODEXP_SEQ_FINAL_CONV_EN
            34);
`else
            33);
`endif

        mem[0] = 32'h0;
        run_case("zero", 1, 8'h20, 0, cyc);

        mem[0] = 32'h0000_0001;
        mem[1] = 32'hFFFF_FFFF;
        run_case("two", 2, 8'h20, 0, cyc);
        chk("two_addr_steps", addr_q.size(), 2);
        chk("two_addr_last", addr_q[$], 1);

        base = log_q.size();
        run_case("len0", 0, 8'h20, 0, cyc);
`ifndef MODEXP_SEQ_FINAL_CONV_EN
        chk("len0_cycles", cyc, 2);
        chk("len0_no_ops", log_q.size() - base, 0);
`else
        chk("len0_conv_op", log_q[base], {3'd3, 3'd4, 1'b0});
`endif

        // abort during the first multiply wait
        mem[0] = 32'h8000_0000;
        base = log_q.size();
        @(negedge clk);
        exp_length = 8'd1;
        length = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (log_q.size() < base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_mul", log_q.size() - base, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("abort");
        run_case("after_abort", 1, 8'h20, 0, cyc);

        mem[0] = 32'hA5A5_0F0F;
        run_case("hammer", 1, 8'h20, 1, cyc);

        for (int r = 0; r < 4; r++) begin
            elen = $urandom_range(1, 3);
            for (int w = 0; w < elen; w++)
                mem[w] = (r % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
            run_case($sformatf("rnd%0d", r), elen, 8'($urandom_range(1, 255)), 0, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/modexp_seq.md
Name: modexp_seq

Overview:
Square-and-multiply sequencer that drives one montprod core to compute a Montgomery-domain modular exponentiation.
- Scans an exponent held in a 32-bit-word memory, MSB-first.
- Issues one square per exponent bit, plus one multiply per set bit.
- Steers montprod operand and destination bank selects, ping-ponging the running result between banks R0 and R1.
- Sits between the top-level modexp register interface and montprod.

Parameters:
EXP_ADDR_W, 8, exponent memory address width.
GUARD_CYCLES, 1, cycles after an mp_calculate pulse during which mp_ready is ignored (range 1..3).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle start request; sampled only while ready=1
ready  out  1  idle/complete flag
length  in  8  operand length in 32-bit words; latched at start
exp_length  in  8  exponent length in words; latched at start
exp_addr  out  EXP_ADDR_W  exponent memory read address
exp_data  in  32  exponent word; valid one cycle after exp_addr (registered memory)
mp_calculate  out  1  single-cycle start pulse to montprod
mp_ready  in  1  montprod ready
mp_length  out  8  latched length, to montprod
mp_opa_sel  out  3  operand A bank: 0=R0, 1=R1, 2=P (message residue), 3=ONE (R mod M), 4=LIT1 (plain 1)
mp_opb_sel  out  3  operand B bank, same encoding
mp_dst_sel  out  1  result bank: 0=R0, 1=R1
result_sel  out  3  bank holding final result; valid while ready=1 after completion

Behaviour:
Reset values:
- ready=1, mp_calculate=0.
- mp_opa_sel=mp_opb_sel=3, mp_dst_sel=0, result_sel=3.
- exp_addr=0, mp_length=0, state=IDLE.
- Reset mid-operation aborts immediately with the same values. montprod is not stalled and must be reset alongside.

Start:
- start with ready=1 latches length and exp_length.
- ready drops next cycle.
- Sets cur=ONE(3), word index w=0, bit index b=31.
- start while ready=0 is ignored.

States:
- IDLE: wait for start. Go to FETCH, or to DONE if exp_length=0.
- FETCH: drive exp_addr=w. Go to LATCH.
- LATCH: capture exp_data into the word register. Go to SQ_START.
- SQ_START: drive opa=opb=cur, dst=~last_dst (first op of a run: dst=0). Pulse mp_calculate for one cycle. Go to SQ_WAIT.
- SQ_WAIT: ignore mp_ready for GUARD_CYCLES, then wait for mp_ready=1.
  - On ready: cur=dst.
  - If word[b]=1, go to MUL_START; else go to NEXT.
- MUL_START: opa=cur, opb=2 (P), dst=~cur. Pulse mp_calculate. Go to MUL_WAIT.
- MUL_WAIT: same guard and wait as SQ_WAIT. cur=dst. Go to NEXT.
- NEXT:
  - If b>0: b=b-1, go to SQ_START.
  - Else if w=exp_length-1: go to CONV_START (feature on) or DONE.
  - Else: w=w+1, b=31, go to FETCH.
- DONE: result_sel=cur, ready=1. Go to IDLE.

Select and counter rules:
- Selects hold stable from each *_START through the end of the matching *_WAIT.
- Destination never equals either operand bank.
- mp_calculate is never asserted while in a *_WAIT state or while mp_ready=0.
- Word counter compares at 8 bits. exp_length=255 scans 8160 bits with no wrap.
- Total montprod ops = 32*exp_length + popcount(exponent) (+1 with the optional feature).

Optional Feature:
MODEXP_SEQ_FINAL_CONV_EN
- Defined: after the last bit, CONV_START issues montprod(opa=cur, opb=4 LIT1, dst=~cur), and CONV_WAIT waits for it. result_sel then holds the normal-domain result. exp_length=0 also performs this one conversion (ONE -> dst R0).
- Undefined: CONV states are absent. result_sel holds the Montgomery-domain result.

Test Plan:
Use a behavioral montprod model that asserts ready 10 cycles after calculate, and log every (opa, opb, dst) triple.
- exp_length=1, exp word 0x80000000 -> 33 pulses.
  - First op: (3,3,0). Second op: (0,2,1). Then 31 squares alternating dst.
  - result_sel=0. ready returns 1 after the last op.
- exp_length=1, word 0x00000000 -> 32 squares, the first being (3,3,0). result_sel=1.
- exp_length=2, words {0x00000001, 0xFFFFFFFF}:
  - exp_addr reads 0 then 1.
  - 64 squares + 33 multiplies = 97 pulses.
  - No mp_calculate while the model reports busy.
- exp_length=0 -> no pulses, ready back in 2 cycles, result_sel=3. With the feature: one pulse (3,4,0), result_sel=0.
- Assert reset for 1 cycle during MUL_WAIT of the first case -> all outputs at reset values next cycle. A subsequent start runs to completion correctly.
- start pulsed repeatedly while busy -> ignored; op count unchanged. Length 0x20 appears on mp_length from the cycle after start.
